// File: rtl/hbc_pkg.sv
// Shared definitions for the HBC host bus front end: default bus widths and the
// packed write-event record.
package hbc_pkg;

  localparam int HBC_ADDR_W = 3;
  localparam int HBC_DATA_W = 8;

  typedef struct packed {
    logic [HBC_ADDR_W-1:0] addr;
    logic [HBC_DATA_W-1:0] data;
  } hbc_wr_evt_t;

endpackage

// File: rtl/hbc_sync2.sv
// Generic two-flop synchronizer with a configurable reset value, used to bring
// asynchronous host pins into the clk domain.
module hbc_sync2 #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1_r;
  logic [WIDTH-1:0] s2_r;

  // Two-stage resynchronization chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r <= RST_VAL;
      s2_r <= RST_VAL;
    end else begin
      s1_r <= d;
      s2_r <= s1_r;
    end
  end

  assign q = s2_r;

endmodule

// File: rtl/hbc_bus_sync.sv
// HBC host bus front end: synchronizes host strobes and pins, turns each
// completed host write into a queued {address, data} event and flags host reads.
module hbc_bus_sync
  import hbc_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = HBC_ADDR_W,
  parameter int DATA_W = HBC_DATA_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    WRn,
  input  logic                    RDn,
  input  logic [ADDR_W-1:0]       address,
  input  logic [DATA_W-1:0]       data_in,
  output logic                    wr_valid,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [DATA_W-1:0]       wr_data,
  input  logic                    wr_ready,
  output logic                    rd_strobe,
  output logic [ADDR_W-1:0]       rd_addr,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    overflow,
  input  logic                    clr_ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int EVT_W = ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};

  logic [1:0]       strb_s2_s;
  logic [EVT_W-1:0] bus_s2_s;
  logic             wr_s2_s;
  logic             rd_s2_s;
  logic             wr_s3_r;
  logic             rd_s3_r;
  logic [EVT_W-1:0] bus_s3_r;

  logic [EVT_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] rd_ptr_nxt_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic [EVT_W-1:0] head_r;
  logic [EVT_W-1:0] head_nxt_s;
  logic             wr_valid_r;
  logic             overflow_r;
  logic [ADDR_W-1:0] rd_addr_r;

  logic wr_evt_s;
  logic rd_evt_s;
  logic pop_s;
  logic full_s;
  logic push_ok_s;
  logic drop_s;

  // Strobes idle high so that reset release never looks like an edge.
  hbc_sync2 #(.WIDTH(2), .RST_VAL(2'b11)) u_strb_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({WRn, RDn}),
    .q     (strb_s2_s)
  );

  hbc_sync2 #(.WIDTH(EVT_W), .RST_VAL({EVT_W{1'b0}})) u_bus_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({address, data_in}),
    .q     (bus_s2_s)
  );

  assign wr_s2_s = strb_s2_s[1];
  assign rd_s2_s = strb_s2_s[0];

  // Third stage: edge-detect history plus the bus value sampled alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_s3_r  <= 1'b1;
      rd_s3_r  <= 1'b1;
      bus_s3_r <= {EVT_W{1'b0}};
    end else begin
      wr_s3_r  <= wr_s2_s;
      rd_s3_r  <= rd_s2_s;
      bus_s3_r <= bus_s2_s;
    end
  end

  // bus_s3_r still holds the value sampled while WRn was low.
  assign wr_evt_s  = wr_s2_s & ~wr_s3_r;
  assign rd_evt_s  = ~rd_s2_s & rd_s3_r;
  assign pop_s     = wr_valid_r & wr_ready;
  assign full_s    = (count_r == FULL_CNT);
  assign push_ok_s = wr_evt_s & (~full_s | pop_s);
  assign drop_s    = wr_evt_s & full_s & ~pop_s;

  // Next read pointer, occupancy and head entry for the fall-through output.
  always_comb begin
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    head_nxt_s   = head_r;
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + 1'b1;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    case ({push_ok_s, pop_s})
      2'b10:   count_nxt_s = count_r + 1'b1;
      2'b01:   count_nxt_s = count_r - 1'b1;
      default: count_nxt_s = count_r;
    endcase
    // When the new head is the entry being written this edge, bypass the array.
    if (push_ok_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_nxt_s = bus_s3_r;
    end else if (count_nxt_s != ZERO_CNT) begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end else begin
      head_nxt_s = head_r;
    end
  end

  // Event storage array.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= bus_s3_r;
    end
  end

  // FIFO control, sticky overflow and read address capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= ZERO_CNT;
      head_r     <= {EVT_W{1'b0}};
      wr_valid_r <= 1'b0;
      overflow_r <= 1'b0;
      rd_addr_r  <= {ADDR_W{1'b0}};
    end else begin
      rd_ptr_r   <= rd_ptr_nxt_s;
      count_r    <= count_nxt_s;
      head_r     <= head_nxt_s;
      wr_valid_r <= (count_nxt_s != ZERO_CNT);
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (clr_ovf) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
      if (rd_evt_s) begin
        rd_addr_r <= bus_s2_s[EVT_W-1 -: ADDR_W];
      end else begin
        rd_addr_r <= rd_addr_r;
      end
    end
  end

  assign wr_valid   = wr_valid_r;
  assign wr_addr    = head_r[EVT_W-1 -: ADDR_W];
  assign wr_data    = head_r[DATA_W-1:0];
  assign fifo_count = count_r;
  assign overflow   = overflow_r;
  assign rd_strobe  = rd_evt_s;
  assign rd_addr    = rd_addr_r;

endmodule

// File: tb/tb_hbc_bus_sync.sv
// Self-checking bench for hbc_bus_sync: directed vector table, corner-case
// sequences and randomized host traffic against an event-level queue model.
module tb_hbc_bus_sync;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       WRn;
  logic       RDn;
  logic [2:0] address;
  logic [7:0] data_in;
  logic       wr_valid;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       rd_strobe;
  logic [2:0] rd_addr;
  logic [3:0] fifo_count;
  logic       overflow;
  logic       clr_ovf;

  hbc_bus_sync dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .WRn        (WRn),
    .RDn        (RDn),
    .address    (address),
    .data_in    (data_in),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .rd_strobe  (rd_strobe),
    .rd_addr    (rd_addr),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [10:0] evt;
  } pend_t;

  typedef struct {
    logic [2:0] a;
    logic [7:0] d;
    logic [2:0] exp_a;
    logic [7:0] exp_d;
  } vec_t;

  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [10:0] mq[$];
  pend_t       pend_q[$];
  logic        ovf_m;
  logic [2:0]  rd_addr_m;
  int          rd_due;
  logic [2:0]  rd_pend_addr;
  bit          rand_ready = 1'b0;
  bit          rand_clr = 1'b0;
  vec_t        vt[4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    pend_q.delete();
    ovf_m     = 1'b0;
    rd_addr_m = 3'd0;
    rd_due    = -100;
  endtask

  // One clock: advance the model on the edge, then compare all outputs.
  task automatic step();
    bit    pop;
    bit    dropped;
    pend_t p;
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      pop     = (mq.size() > 0) && wr_ready;
      dropped = 1'b0;
      if (pop) void'(mq.pop_front());
      if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
        p = pend_q.pop_front();
        if (mq.size() < 8) mq.push_back(p.evt);
        else begin
          ovf_m   = 1'b1;
          dropped = 1'b1;
        end
      end
      if (!dropped && clr_ovf) ovf_m = 1'b0;
      if (cyc == rd_due + 1) rd_addr_m = rd_pend_addr;
    end
    #1;
    check("wr_valid", 32'(wr_valid), 32'(mq.size() > 0));
    check("fifo_count", 32'(fifo_count), 32'(mq.size()));
    check("overflow", 32'(overflow), 32'(ovf_m));
    check("rd_strobe", 32'(rd_strobe), 32'(rst_n && cyc == rd_due));
    check("rd_addr", 32'(rd_addr), 32'(rd_addr_m));
    if (mq.size() > 0) check("wr_head", 32'({wr_addr, wr_data}), 32'(mq[0]));
    if (rand_ready) wr_ready = 1'($urandom);
    if (rand_clr) clr_ovf = ($urandom_range(0, 9) == 0);
  endtask

  task automatic host_write(input logic [2:0] a, input logic [7:0] d, input int lo, input int hi);
    address = a;
    data_in = d;
    WRn     = 1'b0;
    repeat (lo) step();
    pend_q.push_back('{due: cyc + 3, evt: {address, data_in}});
    WRn = 1'b1;
    step();
    address = 3'($urandom);
    data_in = 8'($urandom);
    repeat (hi - 1) step();
  endtask

  task automatic host_read(input logic [2:0] a, input int lo, input int hi);
    int n = 0;
    address      = a;
    RDn          = 1'b0;
    rd_due       = cyc + 2;
    rd_pend_addr = a;
    repeat (lo) begin step(); n += int'(rd_strobe); end
    RDn = 1'b1;
    repeat (hi) begin step(); n += int'(rd_strobe); end
    check("rd_pulse_count", 32'(n), 32'd1);
    check("rd_addr_held", 32'(rd_addr), 32'(a));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{a: 3'd5, d: 8'hA5, exp_a: 3'd5, exp_d: 8'hA5};
    vt[1] = '{a: 3'd0, d: 8'h00, exp_a: 3'd0, exp_d: 8'h00};
    vt[2] = '{a: 3'd7, d: 8'hFF, exp_a: 3'd7, exp_d: 8'hFF};
    vt[3] = '{a: 3'd2, d: 8'h3C, exp_a: 3'd2, exp_d: 8'h3C};

    rst_n = 1'b0; WRn = 1'b1; RDn = 1'b1; address = 3'd0; data_in = 8'd0;
    wr_ready = 1'b0; clr_ovf = 1'b0;
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();

    // Single writes: wr_valid 3 edges after WRn is sampled high, for one cycle.
    wr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      address = vt[i].a; data_in = vt[i].d; WRn = 1'b0;
      repeat (4) step();
      pend_q.push_back('{due: cyc + 3, evt: {address, data_in}});
      WRn = 1'b1;
      step(); check("lat_e1", 32'(wr_valid), 32'd0);
      step(); check("lat_e2", 32'(wr_valid), 32'd0);
      step(); check("lat_e3", 32'(wr_valid), 32'd1);
      check("tbl_addr", 32'(wr_addr), 32'(vt[i].exp_a));
      check("tbl_data", 32'(wr_data), 32'(vt[i].exp_d));
      step(); check("tbl_popped", 32'(wr_valid), 32'd0);
      check("tbl_count", 32'(fifo_count), 32'd0);
      repeat (2) step();
    end

    // Fill and overflow, then in-order drain and overflow clear.
    wr_ready = 1'b0;
    for (int i = 0; i < 9; i++) host_write(3'(i), 8'(i), 4, 3);
    check("fill_count", 32'(fifo_count), 32'd8);
    check("fill_ovf", 32'(overflow), 32'd1);
    wr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", 32'(wr_valid), 32'd1);
      check("drain_data", 32'(wr_data), 32'(i));
      step();
    end
    check("drain_empty", 32'(wr_valid), 32'd0);
    check("ovf_before_clr", 32'(overflow), 32'd1);
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Full FIFO with a pop on the exact push edge.
    wr_ready = 1'b0;
    for (int i = 0; i < 8; i++) host_write(3'(i), 8'(16 + i), 4, 3);
    address = 3'd1; data_in = 8'h18; WRn = 1'b0;
    repeat (4) step();
    pend_q.push_back('{due: cyc + 3, evt: {address, data_in}});
    WRn = 1'b1;
    step(); step();
    wr_ready = 1'b1; step(); wr_ready = 1'b0;
    check("simul_count", 32'(fifo_count), 32'd8);
    check("simul_ovf", 32'(overflow), 32'd0);
    repeat (2) step();
    wr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("simul_order", 32'(wr_data), 32'(17 + i));
      step();
    end

    // Read pulse.
    host_read(3'd3, 5, 3);
    check("read_no_write", 32'(fifo_count), 32'd0);

    // Reset in the middle of a host write.
    address = 3'd6; data_in = 8'h66; WRn = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_valid", 32'(wr_valid), 32'd0);
    check("rst_addr", 32'(wr_addr), 32'd0);
    check("rst_data", 32'(wr_data), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_rdstb", 32'(rd_strobe), 32'd0);
    check("rst_rdaddr", 32'(rd_addr), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    #1;
    WRn = 1'b1;
    repeat (4) step();
    check("rst_no_evt", 32'(fifo_count), 32'd0);
    wr_ready = 1'b0;
    host_write(3'd4, 8'hC3, 4, 4);
    check("post_rst_count", 32'(fifo_count), 32'd1);
    check("post_rst_head", 32'({wr_addr, wr_data}), 32'({3'd4, 8'hC3}));
    wr_ready = 1'b1;
    step();

    // New data presented exactly 3 clocks before WRn rises is the value captured.
    address = 3'd2; data_in = 8'h11; WRn = 1'b0;
    repeat (3) step();
    data_in = 8'h99;
    repeat (3) step();
    pend_q.push_back('{due: cyc + 3, evt: {address, data_in}});
    WRn = 1'b1;
    repeat (3) step();
    check("setup_data", 32'(wr_data), 32'h99);
    repeat (3) step();

    // Randomized host traffic with random ready and overflow clears.
    rand_ready = 1'b1;
    rand_clr   = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) < 6)
        host_write(3'($urandom), 8'($urandom), $urandom_range(3, 6), $urandom_range(3, 5));
      else
        host_read(3'($urandom), $urandom_range(3, 5), $urandom_range(3, 5));
    end
    rand_ready = 1'b0;
    rand_clr   = 1'b0;
    wr_ready   = 1'b1;
    clr_ovf    = 1'b0;
    repeat (12) step();
    check("final_empty", 32'(fifo_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hbc_bus_sync.md
# hbc_bus_sync

Clock-domain front end for the HBC 8-bit parallel host bus. It samples the asynchronous host strobes (WRn, RDn), address and data pins into the `clk` domain through two-flop synchronizers. Each completed host write becomes a single {address, data} event, queued in a small first-word-fall-through FIFO. Core logic drains the FIFO with a valid/ready handshake; it also receives a one-cycle pulse for every host read.

## Interface
Parameters:
- DEPTH, 8, write-event FIFO depth; power of two, ≥2
- ADDR_W, 3, host address width
- DATA_W, 8, host data width

Ports:
- clk  in  1  system clock; one clock only
- rst_n  in  1  reset, asynchronous, active-low
- WRn  in  1  host write strobe, async, active-low
- RDn  in  1  host read strobe, async, active-low
- address  in  ADDR_W  host address pins, async
- data_in  in  DATA_W  host data pins, input side of the pad tri-state, async
- wr_valid  out  1  FIFO head holds a write event
- wr_addr  out  ADDR_W  head event address
- wr_data  out  DATA_W  head event data
- wr_ready  in  1  core accepts the head event
- rd_strobe  out  1  one-cycle pulse per host read
- rd_addr  out  ADDR_W  address of the last host read; holds until the next read
- fifo_count  out  $clog2(DEPTH)+1  number of queued events
- overflow  out  1  sticky flag: a write event was dropped
- clr_ovf  in  1  clears overflow

## Operation
- Synchronization:
  - WRn, RDn, address and data_in each pass through 2 flops (s1, s2).
  - WRn and RDn also get a third flop (s3) for edge detection.
  - address and data_in also get a third flop (a3/d3), aligned with s3.
- Write event:
  - Condition: wr_s2 == 1 && wr_s3 == 0, the rising edge of WRn at the end of the write.
  - Captured values: a3 and d3, sampled while WRn was still low.
- Read event:
  - Condition: rd_s2 == 0 && rd_s3 == 1, the falling edge of RDn.
  - Action: rd_strobe = 1 for exactly one cycle; rd_addr ← a2 on the same edge.
- FIFO behaviour:
  - Circular buffer; pointers wrap modulo DEPTH.
  - First-word fall-through: wr_addr/wr_data show the head entry whenever wr_valid = 1.
  - Pop occurs when wr_valid && wr_ready.
  - Push when fifo_count == DEPTH and no pop in the same cycle: event dropped, overflow ← 1.
  - Push and pop in the same cycle while full: both accepted, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: pop is impossible (wr_valid = 0); the push lands.
- overflow:
  - Set wins over clr_ovf in the same cycle.
  - Otherwise clr_ovf clears it.
- Values on wr_addr/wr_data are don't-care while wr_valid = 0; hold the last head value.
- Reset (asynchronous assertion) clears:
  - all synchronizer flops to the idle bus state: strobes = 1, address/data = 0;
  - pointers and fifo_count to 0;
  - wr_valid, rd_strobe and overflow to 0;
  - rd_addr to 0.
- Synchronizer reset value of 1 on the strobes guarantees that no spurious event fires at reset release.
- Reset during a host write cycle: the event is lost. After release, the next WRn rising edge produces a normal event.

## Timing
- Host requirements, in clk periods (Tclk):
  - WRn and RDn low ≥ 3 Tclk and high ≥ 3 Tclk.
  - address/data stable from ≥ 3 Tclk before WRn rises until ≥ 1 Tclk after it.
- Write latency:
  - Measured from the first clk edge that samples WRn = 1 to wr_valid = 1: 3 clk edges (s1 → s2/edge detect → FIFO write).
  - Host-pin to wr_valid latency is therefore 3–4 cycles, depending on phase.
- Read latency: from the first clk edge that samples RDn = 0 to rd_strobe: 2 clk edges.
- Pop: takes effect on the clk edge where wr_valid && wr_ready. The next entry appears in the same cycle after that edge, with no bubble.
- fifo_count and overflow are registered and update on the same edge as the push or pop.
- Throughput: 1 event per host write. Host writes are inherently ≥ 6 Tclk apart.

## Structure
- Shared package hbc_pkg:
  - constants: HBC_ADDR_W = 3, HBC_DATA_W = 8;
  - typedef hbc_wr_evt_t as a packed {addr, data}.
- One sub-module, hbc_sync2: generic 2-flop synchronizer.
  - Parameters: width and reset value.
  - Instantiated for the strobes (reset value 1) and for address/data (reset value 0).
- Edge detectors, a3/d3 alignment and the FIFO stay inline in hbc_bus_sync.

## Test plan
- Single write:
  - Stimulus: address = 5, data = 0xA5, WRn low for 4 Tclk then high; wr_ready = 1.
  - Required: wr_valid pulses for 1 cycle with wr_addr = 5 and wr_data = 0xA5, 3 edges after WRn is sampled high; fifo_count returns to 0.
- Fill and overflow:
  - Stimulus: wr_ready = 0, 9 writes with data 0x00..0x08.
  - Required: fifo_count = 8 and overflow = 1. Then raise wr_ready: events drain in order 0x00..0x07, 0x08 is absent; pulsing clr_ovf clears overflow.
- Full, simultaneous push and pop:
  - Stimulus: FIFO full; wr_ready pulsed for 1 cycle on the exact push edge.
  - Required: fifo_count stays 8, overflow stays 0, order preserved.
- Read pulse:
  - Stimulus: address = 3, RDn low for 5 Tclk.
  - Required: exactly one rd_strobe cycle with rd_addr = 3; no write event.
- Reset mid-write:
  - Stimulus: assert rst_n low while WRn is low, release it, then raise WRn.
  - Required: all outputs are 0 during reset; no event is queued for the interrupted write; the following normal write is queued correctly.
- Data change at the setup boundary:
  - Stimulus: data changes 3 Tclk before WRn rises.
  - Required: the new value is captured, not the old one.
